// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared types and constants for the fetch stage.
//  - fetch_state_e : FSM states REQ/WAIT/HOLD/DROP
//  - PC_RESET_DEF / EXC_VEC_DEF : default reset PC and exception vector
//  - misaligned()  : word-alignment test for a PC
package fetch_ctrl_pkg;

  localparam int FETCH_STATE_SIZE = 2;

  typedef enum logic [FETCH_STATE_SIZE-1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_HOLD = 2'd2,
    FETCH_DROP = 2'd3
  } fetch_state_e;

  localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;

  function automatic logic misaligned(input logic [31:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: instruction-memory request/response port.
//  req    : request valid (master -> slave)
//  addr   : request address (master -> slave)
//  gnt    : request accepted this cycle (slave -> master)
//  rvalid : read data valid (slave -> master)
//  rdata  : read data (slave -> master)
interface fetch_ctrl_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_buffer.sv
// fetch_buffer: F/D holding registers (F_PC, F_instr, F_valid, F_adel).
//  clk, reset    : clock, synchronous active-low reset
//  pc_ld/pc_in   : load a new F_PC
//  instr_ld/..in : capture a returned word, mark valid
//  adel_set      : mark the current PC as a misaligned fetch (word forced 0)
//  inv           : drop valid/adel (word and PC are kept unless also loaded)
module fetch_buffer
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_ld,
  input  logic [31:0] pc_in,
  input  logic        instr_ld,
  input  logic [31:0] instr_in,
  input  logic        adel_set,
  input  logic        inv,
  output logic [31:0] F_PC,
  output logic [31:0] F_instr,
  output logic        F_valid,
  output logic        F_adel
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      F_PC    <= PC_RESET;
      F_instr <= '0;
      F_valid <= 1'b0;
      F_adel  <= 1'b0;
    end else begin
      if (pc_ld) F_PC <= pc_in;
      if (instr_ld) begin
        F_instr <= instr_in;
        F_valid <= 1'b1;
        F_adel  <= 1'b0;
      end else if (adel_set) begin
        F_instr <= '0;
        F_valid <= 1'b1;
        F_adel  <= 1'b1;
      end else if (inv) begin
        F_valid <= 1'b0;
        F_adel  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage sequencer, one outstanding instruction-memory request.
//  clk, reset        : clock, synchronous active-low reset
//  next_PC           : NPC result for the buffered word
//  stall             : D not accepting this cycle
//  redirect/_PC      : abandon current fetch, restart at redirect_PC
//  exc_redirect_en   : misaligned next_PC goes to EXC_VEC when set
//  im                : instruction-memory master port
//  F_PC/F_instr/F_valid/F_adel : F/D register contents
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEF,
  parameter logic [31:0] EXC_VEC  = EXC_VEC_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   next_PC,
  input  logic          stall,
  input  logic          redirect,
  input  logic [31:0]   redirect_PC,
  input  logic          exc_redirect_en,
  fetch_ctrl_if.master  im,
  output logic [31:0]   F_PC,
  output logic [31:0]   F_instr,
  output logic          F_valid,
  output logic          F_adel
);

  fetch_state_e state;
  // Low for the cycle following reset so im_req stays 0 while reset is applied
  // and the first cycle after release is the first REQ cycle.
  logic         live;
  logic         pc_bad;
  logic         pc_ld, instr_ld, adel_set, inv;
  logic [31:0]  pc_in;

  assign pc_bad  = misaligned(F_PC);
  assign im.req  = live && (state == FETCH_REQ) && !pc_bad;
  assign im.addr = F_PC;

  // Buffer control decode; redirect overrides every state action.
  always_comb begin
    pc_ld    = 1'b0;
    pc_in    = redirect_PC;
    instr_ld = 1'b0;
    adel_set = 1'b0;
    inv      = 1'b0;
    if (redirect) begin
      pc_ld = 1'b1;
      inv   = 1'b1;
    end else begin
      case (state)
        FETCH_REQ:  adel_set = live && pc_bad;
        FETCH_WAIT: instr_ld = im.rvalid;
        FETCH_HOLD: if (!stall) begin
          pc_ld = 1'b1;
          inv   = 1'b1;
          pc_in = (misaligned(next_PC) && exc_redirect_en) ? EXC_VEC : next_PC;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= FETCH_REQ;
      live  <= 1'b0;
    end else begin
      live <= 1'b1;
      if (redirect) begin
        // A read still in flight must be drained before the next request.
        // If it returns in this same cycle it is already gone, so go to REQ.
        if ((state == FETCH_WAIT || state == FETCH_DROP) && !im.rvalid)
          state <= FETCH_DROP;
        else
          state <= FETCH_REQ;
      end else begin
        case (state)
          FETCH_REQ: if (live) begin
            if (pc_bad)       state <= FETCH_HOLD;
            else if (im.gnt)  state <= FETCH_WAIT;
          end
          FETCH_WAIT: if (im.rvalid) state <= FETCH_HOLD;
          FETCH_HOLD: if (!stall)    state <= FETCH_REQ;
          FETCH_DROP: if (im.rvalid) state <= FETCH_REQ;
          default:                   state <= FETCH_REQ;
        endcase
      end
    end
  end

  fetch_buffer #(.PC_RESET(PC_RESET)) u_buf (
    .clk      (clk),
    .reset    (reset),
    .pc_ld    (pc_ld),
    .pc_in    (pc_in),
    .instr_ld (instr_ld),
    .instr_in (im.rdata),
    .adel_set (adel_set),
    .inv      (inv),
    .F_PC     (F_PC),
    .F_instr  (F_instr),
    .F_valid  (F_valid),
    .F_adel   (F_adel)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios plus a randomized run against a
// transaction-level model (expected fetch/accept PC streams and a memory
// content function).
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] next_PC = '0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_PC = '0;
  logic        exc_redirect_en = 1'b0;
  logic [31:0] F_PC, F_instr;
  logic        F_valid, F_adel;

  fetch_ctrl_if im();

  fetch_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .next_PC         (next_PC),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_PC     (redirect_PC),
    .exc_redirect_en (exc_redirect_en),
    .im              (im),
    .F_PC            (F_PC),
    .F_instr         (F_instr),
    .F_valid         (F_valid),
    .F_adel          (F_adel)
  );

  always #5 clk = ~clk;

  int total = 0, passed = 0;

  bit          auto_mem = 0, model_on = 0, npc_fixed = 0;
  logic [31:0] npc_val = '0;
  int          gnt_pct = 0, stall_pct = 0, redir_pct = 0, lat_max = 0;
  bit          busy = 0;
  int          lat_cnt = 0;
  logic [31:0] pend_addr = '0;
  logic [31:0] exp_fetch = '0, exp_acc = '0;
  int          accepts = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  // One clock: model checks on pre-edge values, edge, then new stimulus at +1.
  task automatic step();
    bit g, acc, rd;
    logic [31:0] ga;
    g   = im.req && im.gnt;
    ga  = im.addr;
    acc = F_valid && !stall && !redirect;
    rd  = redirect;
    if (model_on) begin
      if (busy) begin
        total++;
        if (im.req !== 1'b0) $display("FAIL single_outstanding: im_req=%b want 0", im.req);
        else passed++;
      end
      if (g) begin
        total++;
        if (ga !== exp_fetch) $display("FAIL fetch_addr: got %h want %h", ga, exp_fetch);
        else passed++;
        exp_fetch += 32'd4;
      end
      if (acc) begin
        total++;
        if (F_PC !== exp_acc || F_instr !== memf(exp_acc) || F_adel !== 1'b0)
          $display("FAIL accept: pc=%h instr=%h adel=%b want pc=%h instr=%h adel=0",
                   F_PC, F_instr, F_adel, exp_acc, memf(exp_acc));
        else passed++;
        exp_acc += 32'd4;
        accepts++;
      end
      if (rd) begin
        exp_fetch = redirect_PC;
        exp_acc   = redirect_PC;
      end
    end
    @(posedge clk); #1;
    if (auto_mem) begin
      im.rvalid = 1'b0;
      if (g) begin
        busy      = 1;
        lat_cnt   = $urandom_range(0, lat_max);
        pend_addr = ga;
      end
      if (busy) begin
        if (lat_cnt == 0) begin
          im.rvalid = 1'b1;
          im.rdata  = memf(pend_addr);
          busy      = 0;
        end else lat_cnt--;
      end
      im.gnt      = ($urandom_range(0, 99) < gnt_pct);
      stall       = ($urandom_range(0, 99) < stall_pct);
      redirect    = !im.req && ($urandom_range(0, 99) < redir_pct);
      redirect_PC = $urandom & 32'h0000_FFFC;
    end
    next_PC = npc_fixed ? npc_val : F_PC + 32'd4;
  endtask

  task automatic do_reset();
    auto_mem = 0; model_on = 0; npc_fixed = 0; busy = 0;
    reset = 1'b0; im.gnt = 1'b0; im.rvalid = 1'b0; im.rdata = '0;
    stall = 1'b0; redirect = 1'b0; redirect_PC = '0; exc_redirect_en = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0; im.gnt = 1'b0; im.rvalid = 1'b0; im.rdata = '0;
    step(); step();
    total++; if (im.req !== 1'b0) $display("FAIL rst_req: got %b want 0", im.req); else passed++;
    total++; if (F_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", F_valid); else passed++;
    total++; if (F_PC !== 32'h3000) $display("FAIL rst_pc: got %h want 00003000", F_PC); else passed++;
    total++; if (F_instr !== 32'h0) $display("FAIL rst_instr: got %h want 0", F_instr); else passed++;
    total++; if (F_adel !== 1'b0) $display("FAIL rst_adel: got %b want 0", F_adel); else passed++;
    reset = 1'b1;
    step();
    total++;
    if (im.req !== 1'b1 || im.addr !== 32'h3000)
      $display("FAIL rst_release: req=%b addr=%h want 1 00003000", im.req, im.addr);
    else passed++;
  endtask

  task automatic test_throughput();
    logic [31:0] pc;
    do_reset();
    auto_mem = 1; gnt_pct = 100; stall_pct = 0; redir_pct = 0; lat_max = 0;
    im.gnt = 1'b1;
    for (int c = 0; c < 9; c++) begin
      pc = 32'h3000 + 32'(4 * (c / 3));
      total++;
      if (im.req !== ((c % 3 == 0) ? 1'b1 : 1'b0) || F_valid !== ((c % 3 == 2) ? 1'b1 : 1'b0))
        $display("FAIL tput_pattern c=%0d: req=%b valid=%b", c, im.req, F_valid);
      else passed++;
      if (c % 3 == 0) begin
        total++;
        if (im.addr !== pc) $display("FAIL tput_addr c=%0d: got %h want %h", c, im.addr, pc);
        else passed++;
      end
      if (c % 3 == 2) begin
        total++;
        if (F_instr !== memf(pc) || F_PC !== pc)
          $display("FAIL tput_word c=%0d: pc=%h instr=%h want %h %h", c, F_PC, F_instr, pc, memf(pc));
        else passed++;
      end
      step();
    end
    auto_mem = 0;
  endtask

  task automatic test_gnt_delay();
    do_reset();
    im.gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (im.req !== 1'b1 || im.addr !== 32'h3000)
        $display("FAIL gnt_wait i=%0d: req=%b addr=%h want 1 00003000", i, im.req, im.addr);
      else passed++;
      step();
    end
    im.gnt = 1'b1;
    step();
    im.gnt = 1'b0;
    total++; if (im.req !== 1'b0) $display("FAIL gnt_to_wait: req=%b want 0", im.req); else passed++;
    im.rvalid = 1'b1; im.rdata = memf(32'h3000);
    step();
    im.rvalid = 1'b0;
    total++;
    if (F_valid !== 1'b1 || F_instr !== memf(32'h3000))
      $display("FAIL gnt_data: valid=%b instr=%h want 1 %h", F_valid, F_instr, memf(32'h3000));
    else passed++;
  endtask

  task automatic test_stall_hold();
    do_reset();
    im.gnt = 1'b1; step();
    im.gnt = 1'b0; im.rvalid = 1'b1; im.rdata = memf(32'h3000); step();
    im.rvalid = 1'b0;
    stall = 1'b1; npc_fixed = 1; npc_val = 32'h3100; next_PC = 32'h3100;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (F_valid !== 1'b1 || F_PC !== 32'h3000 || F_instr !== memf(32'h3000) || im.req !== 1'b0)
        $display("FAIL stall_hold i=%0d: valid=%b pc=%h instr=%h req=%b", i, F_valid, F_PC, F_instr, im.req);
      else passed++;
      step();
    end
    stall = 1'b0;
    step();
    total++;
    if (im.req !== 1'b1 || im.addr !== 32'h3100 || F_valid !== 1'b0)
      $display("FAIL stall_release: req=%b addr=%h valid=%b want 1 00003100 0", im.req, im.addr, F_valid);
    else passed++;
    npc_fixed = 0;
  endtask

  task automatic test_redirect();
    do_reset();
    im.gnt = 1'b1; step();
    im.gnt = 1'b0; redirect = 1'b1; redirect_PC = 32'h5000; step();
    redirect = 1'b0; im.rvalid = 1'b1; im.rdata = 32'hDEADBEEF;
    total++;
    if (F_valid !== 1'b0 || im.req !== 1'b0)
      $display("FAIL redir_drop: valid=%b req=%b want 0 0", F_valid, im.req);
    else passed++;
    step();
    im.rvalid = 1'b0;
    total++;
    if (F_valid !== 1'b0 || im.req !== 1'b1 || im.addr !== 32'h5000 || F_instr === 32'hDEADBEEF)
      $display("FAIL redir_restart: valid=%b req=%b addr=%h instr=%h", F_valid, im.req, im.addr, F_instr);
    else passed++;
    im.gnt = 1'b1; step();
    im.gnt = 1'b0; im.rvalid = 1'b1; im.rdata = memf(32'h5000); step();
    im.rvalid = 1'b0;
    total++;
    if (F_valid !== 1'b1 || F_PC !== 32'h5000 || F_instr !== memf(32'h5000))
      $display("FAIL redir_word: valid=%b pc=%h instr=%h want 1 00005000 %h", F_valid, F_PC, F_instr, memf(32'h5000));
    else passed++;
    step();
    im.gnt = 1'b1; step();
    im.gnt = 1'b0; redirect = 1'b1; redirect_PC = 32'h6000;
    im.rvalid = 1'b1; im.rdata = 32'hBADBAD00; step();
    redirect = 1'b0; im.rvalid = 1'b0;
    total++;
    if (im.req !== 1'b1 || im.addr !== 32'h6000 || F_valid !== 1'b0 || F_instr === 32'hBADBAD00)
      $display("FAIL redir_same_cycle: req=%b addr=%h valid=%b instr=%h", im.req, im.addr, F_valid, F_instr);
    else passed++;
  endtask

  task automatic test_misaligned();
    do_reset();
    im.gnt = 1'b1; step();
    im.gnt = 1'b0; im.rvalid = 1'b1; im.rdata = memf(32'h3000); step();
    im.rvalid = 1'b0;
    npc_fixed = 1; npc_val = 32'h3002; next_PC = 32'h3002; exc_redirect_en = 1'b0;
    step();
    total++;
    if (im.req !== 1'b0 || F_PC !== 32'h3002 || F_valid !== 1'b0)
      $display("FAIL adel_noreq: req=%b pc=%h valid=%b want 0 00003002 0", im.req, F_PC, F_valid);
    else passed++;
    step();
    total++;
    if (F_adel !== 1'b1 || F_instr !== 32'h0 || F_valid !== 1'b1 || im.req !== 1'b0)
      $display("FAIL adel_flag: adel=%b instr=%h valid=%b req=%b", F_adel, F_instr, F_valid, im.req);
    else passed++;
    exc_redirect_en = 1'b1;
    step();
    total++;
    if (im.req !== 1'b1 || im.addr !== 32'h4180 || F_adel !== 1'b0 || F_valid !== 1'b0)
      $display("FAIL adel_excvec: req=%b addr=%h adel=%b valid=%b want 1 00004180 0 0", im.req, im.addr, F_adel, F_valid);
    else passed++;
    npc_fixed = 0; exc_redirect_en = 1'b0;
  endtask

  task automatic test_reset_wait();
    do_reset();
    im.gnt = 1'b1; step();
    im.gnt = 1'b0; reset = 1'b0; im.rvalid = 1'b1; im.rdata = 32'hBAD0BAD0; step();
    total++;
    if (F_valid !== 1'b0 || F_PC !== 32'h3000 || im.req !== 1'b0)
      $display("FAIL rstwait_state: valid=%b pc=%h req=%b want 0 00003000 0", F_valid, F_PC, im.req);
    else passed++;
    reset = 1'b1; step();
    im.rvalid = 1'b0;
    total++;
    if (F_valid !== 1'b0 || F_instr !== 32'h0 || im.req !== 1'b1 || im.addr !== 32'h3000)
      $display("FAIL rstwait_stale: valid=%b instr=%h req=%b addr=%h", F_valid, F_instr, im.req, im.addr);
    else passed++;
    step();
    total++;
    if (F_valid !== 1'b0 || im.req !== 1'b1)
      $display("FAIL rstwait_idle: valid=%b req=%b want 0 1", F_valid, im.req);
    else passed++;
  endtask

  task automatic test_random();
    do_reset();
    auto_mem = 1; gnt_pct = 60; stall_pct = 30; redir_pct = 4; lat_max = 2;
    busy = 0; exp_fetch = 32'h3000; exp_acc = 32'h3000; accepts = 0;
    im.gnt = 1'b0; stall = 1'b0; redirect = 1'b0;
    model_on = 1;
    for (int i = 0; i < 400; i++) step();
    model_on = 0; auto_mem = 0;
    total++;
    if (accepts < 20) $display("FAIL rand_progress: accepts=%0d want >=20", accepts);
    else passed++;
  endtask

  initial begin
    im.gnt = 1'b0; im.rvalid = 1'b0; im.rdata = '0;
    test_reset();
    test_throughput();
    test_gnt_delay();
    test_stall_hold();
    test_redirect();
    test_misaligned();
    test_reset_wait();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
